// File: rtl/iob_initiator_pkg.sv
// Shared types and timing defaults for the IO-bus initiator.
// Holds op encodings, the FSM state enum and strobe timing constants.
package iob_initiator_pkg;

  typedef enum logic [1:0] {
    OP_CONO  = 2'd0,
    OP_DATAO = 2'd1,
    OP_CONI  = 2'd2,
    OP_DATAI = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_GAP,
    ST_SET,
    ST_HOLD,
    ST_READ,
    ST_RESP,
    ST_RST
  } state_e;

  localparam int unsigned T_CLR_DEF  = 4;
  localparam int unsigned T_GAP_DEF  = 2;
  localparam int unsigned T_SET_DEF  = 4;
  localparam int unsigned T_READ_DEF = 8;
  localparam int unsigned T_RST_DEF  = 16;

  function automatic logic is_write(op_e op);
    return (op == OP_CONO) || (op == OP_DATAO);
  endfunction

  // Counter load for a state lasting n cycles; it runs n-1 .. 0.
  function automatic logic [7:0] cnt_ld(int unsigned n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/iob_sync2.sv
// Two-flop synchronizer for asynchronous inputs.
// Ports: clk, reset (sync, active-high), d_i async in, q_o synced out.
module iob_sync2 #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/iob_initiator.sv
// IO-bus initiator: turns CONO/DATAO/CONI/DATAI commands into timed
// bus strobes, issues IO-bus resets and synchronizes PI requests.
// Ports: cmd_* handshake in, rsp_* read result out, iobus_* bus side,
// bus_reset_req, pi_req synced PI lines; clk, reset (sync, active-high).
module iob_initiator
  import iob_initiator_pkg::*;
#(
  parameter int unsigned T_CLR  = T_CLR_DEF,
  parameter int unsigned T_GAP  = T_GAP_DEF,
  parameter int unsigned T_SET  = T_SET_DEF,
  parameter int unsigned T_READ = T_READ_DEF,
  parameter int unsigned T_RST  = T_RST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [6:0]  cmd_dev,
  input  logic [35:0] cmd_data,
  output logic        rsp_valid,
  output logic [35:0] rsp_data,
  input  logic        bus_reset_req,
  output logic        iobus_iob_poweron,
  output logic        iobus_iob_reset,
  output logic        iobus_datao_clear,
  output logic        iobus_datao_set,
  output logic        iobus_cono_clear,
  output logic        iobus_cono_set,
  output logic        iobus_iob_fm_datai,
  output logic        iobus_iob_fm_status,
  output logic [6:0]  iobus_ios,
  output logic [35:0] iobus_iob_in,
  input  logic [35:0] iobus_iob_out,
  input  logic [6:0]  iobus_pi_req,
  output logic [6:0]  pi_req
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  op_e         op_q, op_d;
  logic [6:0]  dev_q, dev_d;
  logic [35:0] data_q, data_d;
  logic [35:0] rsp_data_q, rsp_data_d;
  logic        poweron_q;
  logic        last;
  logic        busy;
  logic        wr_phase;

  iob_sync2 #(.W(7)) u_pi_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (iobus_pi_req),
    .q_o   (pi_req)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_CONO;
      dev_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      poweron_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dev_q      <= dev_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      poweron_q  <= 1'b1;
    end
  end

  assign last = (cnt_q == 8'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q - 8'd1;
    op_d       = op_q;
    dev_d      = dev_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Bus reset wins over a command offered in the same cycle.
        if (bus_reset_req) begin
          state_d = ST_RST;
          cnt_d   = cnt_ld(T_RST);
        end else if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          dev_d  = cmd_dev;
          data_d = cmd_data;
          if (is_write(op_e'(cmd_op))) begin
            state_d = ST_CLR;
            cnt_d   = cnt_ld(T_CLR);
          end else begin
            state_d = ST_READ;
            cnt_d   = cnt_ld(T_READ);
          end
        end
      end
      ST_CLR: begin
        if (last) begin
          state_d = ST_GAP;
          cnt_d   = cnt_ld(T_GAP);
        end
      end
      ST_GAP: begin
        if (last) begin
          state_d = ST_SET;
          cnt_d   = cnt_ld(T_SET);
        end
      end
      ST_SET: begin
        if (last) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      ST_READ: begin
        if (last) begin
          rsp_data_d = iobus_iob_out;
          state_d    = ST_RESP;
          cnt_d      = '0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      ST_RST: begin
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE) && (state_q != ST_RST);
  assign wr_phase = (state_q == ST_CLR) || (state_q == ST_GAP)
                 || (state_q == ST_SET) || (state_q == ST_HOLD);

  assign cmd_ready = (state_q == ST_IDLE) && !bus_reset_req && !reset;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;

  assign iobus_iob_poweron   = poweron_q;
  assign iobus_iob_reset     = (state_q == ST_RST);
  assign iobus_cono_clear    = (state_q == ST_CLR) && (op_q == OP_CONO);
  assign iobus_datao_clear   = (state_q == ST_CLR) && (op_q == OP_DATAO);
  assign iobus_cono_set      = (state_q == ST_SET) && (op_q == OP_CONO);
  assign iobus_datao_set     = (state_q == ST_SET) && (op_q == OP_DATAO);
  assign iobus_iob_fm_status = (state_q == ST_READ) && (op_q == OP_CONI);
  assign iobus_iob_fm_datai  = (state_q == ST_READ) && (op_q == OP_DATAI);

  assign iobus_ios    = busy ? dev_q : 7'd0;
  assign iobus_iob_in = wr_phase ? data_q : 36'd0;

endmodule

// File: tb/tb_iob_initiator.sv
// Randomized bench for iob_initiator against a per-cycle trace model.
// Each accepted command expands into its expected cycle-by-cycle outputs.
module tb_iob_initiator;
  import iob_initiator_pkg::*;

  localparam int TC = 4;
  localparam int TG = 2;
  localparam int TS = 4;
  localparam int TR = 8;
  localparam int TT = 16;

  localparam int S_RST = 6;
  localparam int S_CC  = 5;
  localparam int S_CS  = 4;
  localparam int S_DC  = 3;
  localparam int S_DS  = 2;
  localparam int S_ST  = 1;
  localparam int S_DI  = 0;

  typedef struct packed {
    logic [6:0]  stb;
    logic [6:0]  ios;
    logic [35:0] din;
    logic        rv;
    logic        cap;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_dev;
  logic [35:0] cmd_data;
  logic        rsp_valid;
  logic [35:0] rsp_data;
  logic        bus_reset_req;
  logic        poweron, iob_rst, d_clr, d_set, c_clr, c_set;
  logic        fm_di, fm_st;
  logic [6:0]  ios;
  logic [35:0] iob_in;
  logic [35:0] iob_out;
  logic [6:0]  pi_in;
  logic [6:0]  pi_req;

  int n_tests = 0;
  int n_fail  = 0;

  rec_t        q[$];
  logic [35:0] exp_rsp;
  logic        pwr;
  logic [6:0]  p1, p2;
  logic        acc;

  always #5 clk = ~clk;

  iob_initiator dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_op              (cmd_op),
    .cmd_dev             (cmd_dev),
    .cmd_data            (cmd_data),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .bus_reset_req       (bus_reset_req),
    .iobus_iob_poweron   (poweron),
    .iobus_iob_reset     (iob_rst),
    .iobus_datao_clear   (d_clr),
    .iobus_datao_set     (d_set),
    .iobus_cono_clear    (c_clr),
    .iobus_cono_set      (c_set),
    .iobus_iob_fm_datai  (fm_di),
    .iobus_iob_fm_status (fm_st),
    .iobus_ios           (ios),
    .iobus_iob_in        (iob_in),
    .iobus_iob_out       (iob_out),
    .iobus_pi_req        (pi_in),
    .pi_req              (pi_req)
  );

  task automatic chk(input string tag,
                     input logic [35:0] got,
                     input logic [35:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic [1:0] op,
                          input logic [6:0] dev,
                          input logic [35:0] data);
    rec_t r;
    int   clr_b, set_b, rd_b;
    clr_b = (op == OP_CONO) ? S_CC : S_DC;
    set_b = (op == OP_CONO) ? S_CS : S_DS;
    rd_b  = (op == OP_CONI) ? S_ST : S_DI;
    r = '0;
    r.ios = dev;
    if (op == OP_CONO || op == OP_DATAO) begin
      r.din = data;
      for (int i = 0; i < TC; i++) begin
        r.stb = 7'd1 << clr_b;
        q.push_back(r);
      end
      for (int i = 0; i < TG; i++) begin
        r.stb = '0;
        q.push_back(r);
      end
      for (int i = 0; i < TS; i++) begin
        r.stb = 7'd1 << set_b;
        q.push_back(r);
      end
      r.stb = '0;
      q.push_back(r);
    end else begin
      for (int i = 0; i < TR; i++) begin
        r.stb = 7'd1 << rd_b;
        r.cap = (i == TR - 1);
        q.push_back(r);
      end
      r.stb = '0;
      r.cap = 1'b0;
      r.rv  = 1'b1;
      q.push_back(r);
    end
  endtask

  task automatic push_rst();
    rec_t r;
    r = '0;
    r.stb = 7'd1 << S_RST;
    for (int i = 0; i < TT; i++) q.push_back(r);
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model.
  task automatic cycle();
    rec_t r;
    logic idle;
    #4;
    idle = (q.size() == 0);
    if (idle) r = '0;
    else r = q.pop_front();
    chk("strobes",
        {29'd0, iob_rst, c_clr, c_set, d_clr, d_set, fm_st, fm_di},
        {29'd0, r.stb});
    chk("ios", {29'd0, ios}, {29'd0, r.ios});
    chk("iob_in", iob_in, r.din);
    chk("rsp_valid", {35'd0, rsp_valid}, {35'd0, r.rv});
    chk("rsp_data", rsp_data, exp_rsp);
    chk("cmd_ready", {35'd0, cmd_ready},
        {35'd0, idle && !reset && !bus_reset_req});
    chk("poweron", {35'd0, poweron}, {35'd0, pwr});
    chk("pi_req", {29'd0, pi_req}, {29'd0, p2});
    acc = 1'b0;
    if (reset) begin
      q.delete();
      exp_rsp = '0;
      pwr = 1'b0;
      p1 = '0;
      p2 = '0;
    end else begin
      if (r.cap) exp_rsp = iob_out;
      if (idle && bus_reset_req) begin
        push_rst();
      end else if (idle && cmd_valid) begin
        push_cmd(cmd_op, cmd_dev, cmd_data);
        acc = 1'b1;
      end
      pwr = 1'b1;
      p2 = p1;
      p1 = pi_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [6:0] dev,
                       input logic [35:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dev   = dev;
    cmd_data  = data;
    acc = 1'b0;
    for (int n = 0; n < 64 && !acc; n++) cycle();
    chk("accept", {35'd0, acc}, 36'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    for (int n = 0; n < 64 && q.size() != 0; n++) cycle();
    cycle();
    chk("drain", {35'd0, q.size() == 0}, 36'd1);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_dev = '0;
    cmd_data = '0;
    bus_reset_req = 1'b0;
    iob_out = '0;
    pi_in = '0;
    exp_rsp = '0;
    pwr = 1'b0;
    p1 = '0;
    p2 = '0;
    acc = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    cycle();

    // CONO write
    issue(OP_CONO, 7'b0010100, 36'o000000000061);
    drain();

    // DATAI read
    iob_out = 36'o000000000101;
    issue(OP_DATAI, 7'b0010100, 36'd0);
    drain();
    iob_out = '0;

    // bus reset beats a simultaneous command
    bus_reset_req = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = OP_CONO;
    cmd_dev = 7'd5;
    cmd_data = 36'o7;
    cycle();
    bus_reset_req = 1'b0;
    issue(OP_CONO, 7'd5, 36'o7);
    drain();

    // reset during SET of DATAO
    issue(OP_DATAO, 7'd9, 36'o123456701234);
    for (int i = 0; i < TC + TG + 1; i++) cycle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    drain();

    // PI synchronizer step
    pi_in = 7'b0000100;
    for (int i = 0; i < 4; i++) cycle();
    pi_in = '0;
    for (int i = 0; i < 3; i++) cycle();

    // back-to-back CONI
    iob_out = 36'o52;
    issue(OP_CONI, 7'b0010100, 36'd0);
    cmd_valid = 1'b1;
    for (int i = 0; i < TR; i++) cycle();
    iob_out = 36'o17;
    issue(OP_CONI, 7'b0010100, 36'd0);
    drain();

    // randomized traffic
    for (int i = 0; i < 1200; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 2'($urandom);
      cmd_dev = 7'($urandom);
      cmd_data = 36'({$urandom(), $urandom()});
      iob_out = 36'({$urandom(), $urandom()});
      bus_reset_req = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 150) == 0);
      if ($urandom_range(0, 3) == 0) pi_in = 7'($urandom);
      cycle();
    end
    reset = 1'b0;
    bus_reset_req = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_initiator.md
IOB_INITIATOR -- requirements
Module: iob_initiator

Interface
REQ-001 Parameters (name, default, meaning): T_CLR, 4, clear-strobe width in cycles; T_GAP, 2, dead cycles between clear and set; T_SET, 4, set-strobe width; T_READ, 8, read-strobe width (data sampled on last cycle); T_RST, 16, iob_reset width; all 1..255.
REQ-002 Ports (name direction width meaning): clk in 1 clock; reset in 1 synchronous, active-high.
REQ-003 cmd_valid in 1 command offered; cmd_ready out 1 command accepted when both high; cmd_op in 2 (0 CONO, 1 DATAO, 2 CONI, 3 DATAI); cmd_dev in 7 device select, bits [3:9]; cmd_data in 36 write data, bits [0:35].
REQ-004 rsp_valid out 1 one-cycle read-done pulse; rsp_data out 36 sampled read data.
REQ-005 bus_reset_req in 1 request an IO-bus reset pulse.
REQ-006 iobus_iob_poweron, iobus_iob_reset, iobus_datao_clear, iobus_datao_set, iobus_cono_clear, iobus_cono_set, iobus_iob_fm_datai, iobus_iob_fm_status: out 1 each, bus strobes.
REQ-007 iobus_ios out 7 [3:9] device select; iobus_iob_in out 36 [0:35] data to devices; iobus_iob_out in 36 [0:35] data from devices (OR-bus).
REQ-008 iobus_pi_req in 7 [1:7] async PI requests; pi_req out 7 [1:7] synchronized requests.

Function
REQ-009 States: IDLE, CLR, GAP, SET, HOLD, READ, RESP, RST; one 8-bit down-counter times every state.
REQ-010 cmd_ready = 1 only in IDLE with bus_reset_req low.
REQ-011 Acceptance latches op, dev, data; next cycle: write ops (CONO/DATAO) enter CLR, read ops (CONI/DATAI) enter READ.
REQ-012 CLR: cono_clear (CONO) or datao_clear (DATAO) high exactly T_CLR cycles; GAP: all strobes low T_GAP cycles; SET: cono_set/datao_set high exactly T_SET cycles; HOLD: 1 cycle, strobes low; then IDLE.
REQ-013 READ: iob_fm_status (CONI) or iob_fm_datai (DATAI) high exactly T_READ cycles; iobus_iob_out captured into rsp_data on the last READ cycle; RESP: rsp_valid high 1 cycle, strobes low; then IDLE.
REQ-014 iobus_ios = latched dev in every state from CLR/READ through HOLD/RESP inclusive; 0 in IDLE and RST.
REQ-015 iobus_iob_in = latched data in CLR, GAP, SET, HOLD of write ops; 0 otherwise.
REQ-016 At most one strobe high in any cycle; set strobe never high within T_GAP cycles of its clear strobe.
REQ-017 rsp_data holds its value until the next read completes; write ops never pulse rsp_valid.
REQ-018 bus_reset_req sampled only in IDLE, priority over simultaneous cmd_valid (command not accepted); RST: iob_reset high exactly T_RST cycles, ios 0; then IDLE; a request held high re-triggers RST.
REQ-019 bus_reset_req during a command is ignored until IDLE (level, not latched).
REQ-020 pi_req = iobus_pi_req through two flops per bit (latency 2 cycles), independent of the state machine.
REQ-021 Back-to-back: a new command may be accepted in the first IDLE cycle after HOLD/RESP/RST.

Reset
REQ-022 On reset: state IDLE, counter 0, all strobes 0, iob_poweron 0, ios 0, iob_in 0, rsp_valid 0, rsp_data 0, pi_req 0, sync flops 0; cmd_ready 0 while reset high.
REQ-023 iob_poweron rises the first cycle after reset falls and stays 1.
REQ-024 Reset mid-operation: all strobes low on the next cycle, no rsp_valid, latched command discarded.

Structure
REQ-025 Shared package holds op encodings (OP_CONO=0, OP_DATAO=1, OP_CONI=2, OP_DATAI=3), state enum, and default timing constants.
REQ-026 One sub-module, iob_sync2 (7-bit two-flop synchronizer) for pi_req; the rest is a single FSM.

Verification
REQ-027 CONO dev 7'b0010100, data 36'o000000000061 -> ios=0010100 from cycle+1; cono_clear 4 cycles, 2 low, cono_set 4 cycles, iob_in=0o61 throughout, HOLD, IDLE; no datao strobes.
REQ-028 DATAI dev 7'b0010100, device drives iob_out=36'o000000000101 -> iob_fm_datai 8 cycles, rsp_valid 1 cycle after, rsp_data=0o101.
REQ-029 bus_reset_req and cmd_valid high together in IDLE -> cmd_ready 0, iob_reset exactly 16 cycles, then command accepted next IDLE cycle.
REQ-030 Reset asserted during SET of DATAO -> next cycle all strobes, ios, iob_in 0; rsp_valid never pulses; poweron 0 until reset falls.
REQ-031 iobus_pi_req=7'b0000100 asynchronous step -> pi_req=0000100 exactly 2 cycles after first sampling edge.
REQ-032 Two CONI commands back-to-back, device status 0o52 then 0o17 -> two rsp_valid pulses with 0o52 then 0o17; ios 0 for one IDLE cycle between.
